// File: rtl/sm_issue_throttle.sv
// SM issue throttle: buffers scheduler demand as a backlog and issues min(backlog, budget, cap).
// Optional SM_ISSUE_STATS_EN adds total_issued / stall_cycles statistics outputs.
module sm_issue_throttle #(
   parameter int unsigned MAX_ISSUE   = 4,
   parameter int unsigned BACKLOG_W   = 8,
   parameter int unsigned STALL_LIMIT = 16
) (
   input  logic                 clk_sm,
   input  logic                 rst_sm_n,
   input  logic [4:0]           SM_remaining,
   input  logic                 budget_valid,
   input  logic [4:0]           req_count,
   input  logic                 req_valid,
   output logic                 req_ready,
   output logic [4:0]           SM_issued_this_cycle,
   output logic                 issue_valid,
   output logic [BACKLOG_W-1:0] backlog,
   output logic                 stall,
`ifdef SM_ISSUE_STATS_EN
   output logic                 starved,
   output logic [31:0]          total_issued,
   output logic [31:0]          stall_cycles
`else
   output logic                 starved
`endif
);

   localparam int unsigned CW = (BACKLOG_W > 5) ? BACKLOG_W : 5;
   localparam int unsigned BacklogMax = (1 << BACKLOG_W) - 1;
   localparam logic [BACKLOG_W-1:0] ReadyMax = BACKLOG_W'(BacklogMax - 31);
   localparam logic [7:0] StallLimit = 8'(STALL_LIMIT);

   typedef enum logic [1:0] {StIdle, StIssue, StStall} state_e;

   state_e               state_q, state_d;
   logic [BACKLOG_W-1:0] backlog_q, backlog_d;
   logic [4:0]           issued_q, grant;
   logic                 issue_valid_q;
   logic [7:0]           stall_cnt_q, stall_cnt_d;
   logic                 starved_q;
   logic                 accept;
   logic [CW-1:0]        min_w;

   // Only the registered backlog gates acceptance, so a full 31-instruction offer always fits.
   assign req_ready = (backlog_q <= ReadyMax);
   assign accept    = req_valid & req_ready;

   always_comb begin
      min_w = CW'(backlog_q);
      if (CW'(SM_remaining) < min_w) min_w = CW'(SM_remaining);
      if (CW'(MAX_ISSUE) < min_w)    min_w = CW'(MAX_ISSUE);
      grant = budget_valid ? min_w[4:0] : 5'd0;
   end

   always_comb begin
      backlog_d = backlog_q - BACKLOG_W'(grant) + (accept ? BACKLOG_W'(req_count) : '0);
      state_d   = StIdle;
      if (backlog_q != '0) begin
         state_d = (grant != 5'd0) ? StIssue : StStall;
      end
      stall_cnt_d = 8'd0;
      if (state_d == StStall) begin
         stall_cnt_d = (stall_cnt_q == StallLimit) ? stall_cnt_q : stall_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_sm or negedge rst_sm_n) begin
      if (!rst_sm_n) begin
         state_q       <= StIdle;
         backlog_q     <= '0;
         issued_q      <= 5'd0;
         issue_valid_q <= 1'b0;
         stall_cnt_q   <= 8'd0;
         starved_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         backlog_q     <= backlog_d;
         issued_q      <= grant;
         issue_valid_q <= (grant != 5'd0);
         stall_cnt_q   <= stall_cnt_d;
         starved_q     <= (stall_cnt_d == StallLimit);
      end
   end

   assign SM_issued_this_cycle = issued_q;
   assign issue_valid          = issue_valid_q;
   assign backlog              = backlog_q;
   assign stall                = (state_q == StStall);
   assign starved              = starved_q;

`ifdef SM_ISSUE_STATS_EN
   logic [31:0] total_q, stall_cyc_q;

   always_ff @(posedge clk_sm or negedge rst_sm_n) begin
      if (!rst_sm_n) begin
         total_q     <= 32'd0;
         stall_cyc_q <= 32'd0;
      end else begin
         total_q     <= total_q + 32'(grant);
         stall_cyc_q <= stall_cyc_q + 32'(state_d == StStall);
      end
   end

   assign total_issued = total_q;
   assign stall_cycles = stall_cyc_q;
`endif

endmodule

// File: doc/sm_issue_throttle.md
Name: sm_issue_throttle

Overview:
- Consumer end of the SM power-budget interface: takes the per-cycle remaining issue budget from full_control_system and returns the number of instructions actually issued that cycle.
- Buffers ready-instruction demand from the warp scheduler as a backlog count.
- Each cycle, issues min(backlog, budget, MAX_ISSUE) and reports budget stalls and starvation.
- One instance per SM; SM_issued_this_cycle feeds the controller's issued_this_cycle input.

Parameters:
- MAX_ISSUE, 4: hard cap on instructions issued per cycle (1..31).
- BACKLOG_W, 8: width of the backlog counter; BACKLOG_MAX = 2**BACKLOG_W - 1.
- STALL_LIMIT, 16: consecutive stall cycles before starved asserts (1..255).

Ports:
- clk_sm  input  1  SM clock; all state changes on the rising edge.
- rst_sm_n  input  1  asynchronous, active-low reset.
- SM_remaining  input  5  issue budget for this cycle, from the controller.
- budget_valid  input  1  SM_remaining is valid this cycle.
- req_count  input  5  new ready instructions offered this cycle.
- req_valid  input  1  req_count is offered this cycle.
- req_ready  output  1  backlog can accept any req_count this cycle.
- SM_issued_this_cycle  output  5  registered grant count, to the controller.
- issue_valid  output  1  SM_issued_this_cycle is nonzero.
- backlog  output  BACKLOG_W  pending instruction count.
- stall  output  1  FSM is in STALL.
- starved  output  1  stall has persisted for STALL_LIMIT cycles.

Behaviour:
- Reset (async assert, sync release on clk_sm): backlog=0, SM_issued_this_cycle=0, issue_valid=0, state=IDLE, stall=0, starved=0, stall counter=0, stats counters=0.
- Reset asserted mid-operation drops all pending backlog; no partial grant is emitted.
- req_ready (combinational from registered backlog only) = 1 when backlog <= BACKLOG_MAX-31.
- Accept = req_valid & req_ready. Demand with req_valid=1 and req_ready=0 is dropped; the source must hold it.
- Grant, computed combinationally each cycle:
  - grant = 0 if budget_valid=0.
  - Otherwise grant = min(backlog, SM_remaining, MAX_ISSUE), compared at BACKLOG_W bits.
  - Result is always <= 31.
- At each edge:
  - SM_issued_this_cycle <= grant; issue_valid <= (grant != 0).
  - Latency: budget sampled at edge k is reflected in the output after edge k (1 cycle).
  - backlog <= backlog - grant + (accept ? req_count : 0).
  - Same-cycle accept and grant are both applied. The result never exceeds BACKLOG_MAX (guaranteed by req_ready) and never underflows (grant <= backlog).
  - A newly accepted req_count is not issuable until the following cycle.
- FSM next state, evaluated from current-cycle conditions:
  - IDLE: backlog == 0.
  - ISSUE: backlog > 0 and grant > 0.
  - STALL: backlog > 0 and grant == 0 (budget_valid=0 or SM_remaining=0).
  - Any state can move to any state; stall = (state == STALL).
- Stall counter (8-bit):
  - Increments on each edge where the next state is STALL.
  - Saturates at STALL_LIMIT.
  - Clears when the next state is ISSUE or IDLE.
- starved = (stall counter == STALL_LIMIT), registered. It deasserts on the first edge with a grant or an empty backlog.
- SM_remaining > MAX_ISSUE is legal; the grant is clipped to MAX_ISSUE.
- SM_remaining values above the backlog are not carried forward; budget is not banked.

Optional Feature:
- Macro: SM_ISSUE_STATS_EN.
- When defined, add two outputs, each 32-bit and wrapping modulo 2**32, both cleared by reset:
  - total_issued: accumulates grant on every edge.
  - stall_cycles: increments on every edge where the next state is STALL.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle: hold rst_sm_n=0 for 3 cycles, release with no requests -> all outputs 0, state IDLE, req_ready=1.
- Basic issue: req_count=10 accepted once, then SM_remaining=2, budget_valid=1 held -> SM_issued_this_cycle sequence 2,2,2,2,2, then 0; backlog 10,8,6,4,2,0; state returns to IDLE.
- Clip to cap: backlog=20, SM_remaining=31, MAX_ISSUE=4 -> grant 4 per cycle for 5 cycles.
- Simultaneous accept and grant: backlog=5, SM_remaining=3, req_count=7 accepted in the same cycle -> next backlog=9, SM_issued_this_cycle=3.
- Starvation: backlog=6, SM_remaining=0 for 16 cycles -> stall=1 from the first edge, starved=1 after edge 16; then SM_remaining=1 -> grant 1, starved=0 and stall=0 after that edge.
- Backpressure and stats: fill backlog to 225 -> req_ready=0 and offered req_count is dropped, backlog unchanged. With SM_ISSUE_STATS_EN defined, after the basic-issue test total_issued=10.
